// File: rtl/hdmi_timing_decoder.sv
// rtl/hdmi_timing_decoder.sv - recovers pixel coordinates, frame geometry and lock from VDE/CD
module hdmi_timing_decoder #(
  parameter int HW          = 11,
  parameter int VW          = 10,
  parameter bit SYNC_POL    = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          pixclk,
  input  logic          reset,
  input  logic          VDE,
  input  logic [1:0]    CD,
  output logic          pixel_valid,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic [HW-1:0] h_active,
  output logic [VW-1:0] v_active,
  output logic [HW-1:0] h_total,
  output logic          locked
);

  localparam logic [HW-1:0] HMAX = '1;
  localparam logic [VW-1:0] VMAX = '1;

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  state_t        state, state_next;
  logic [3:0]    match_cnt, match_cnt_next;

  // sync levels are stored normalised to "asserted", so a cleared register is deasserted
  logic          vde_r, vde_p, hs_r, hs_p, vs_r, vs_p;
  logic          vde_rise, vde_fall, hs_edge, vs_edge;

  logic [HW-1:0] first_x, first_eff, x_next, new_h, clk_cnt;
  logic [VW-1:0] y_inc, y_next, new_v;
  logic          have_first, have_eff, line_mismatch, line_bad, mis_eff, frame_ok;
  logic [3:0]    match_inc;

  // input register plus one-cycle history for edge detection
  always_ff @(posedge pixclk) begin
    if (reset) begin
      vde_r <= 1'b0;
      hs_r  <= 1'b0;
      vs_r  <= 1'b0;
      vde_p <= 1'b0;
      hs_p  <= 1'b0;
      vs_p  <= 1'b0;
    end else begin
      vde_r <= VDE;
      hs_r  <= (CD[0] == SYNC_POL);
      vs_r  <= (CD[1] == SYNC_POL);
      vde_p <= vde_r;
      hs_p  <= hs_r;
      vs_p  <= vs_r;
    end
  end

  assign vde_rise = vde_r & ~vde_p;
  assign vde_fall = ~vde_r & vde_p;
  assign hs_edge  = hs_r & ~hs_p;
  assign vs_edge  = vs_r & ~vs_p;

  // next coordinates and the closing-frame view; a line ending on the vsync edge still belongs to the old frame
  always_comb begin
    x_next = x;
    if (vde_r) begin
      if (vde_rise)       x_next = '0;
      else if (x != HMAX) x_next = x + 1'b1;
    end
    line_bad  = vde_fall & ((x == HMAX) | (have_first & (x != first_x)));
    mis_eff   = line_mismatch | line_bad;
    first_eff = (vde_fall & ~have_first) ? x : first_x;
    have_eff  = have_first | vde_fall;
    y_inc     = y;
    if (vde_fall && y != VMAX) y_inc = y + 1'b1;
    y_next    = vs_edge ? '0 : y_inc;
    new_v     = y_inc;
    new_h     = '0;
    if (have_eff) new_h = (first_eff == HMAX) ? HMAX : first_eff + 1'b1;
    frame_ok  = ~mis_eff & (new_v != '0) & (new_h == h_active) & (new_v == v_active);
  end

  // coordinate outputs, line-length tracking and per-frame geometry latch
  always_ff @(posedge pixclk) begin
    if (reset) begin
      pixel_valid   <= 1'b0;
      x             <= '0;
      y             <= '0;
      line_start    <= 1'b0;
      frame_start   <= 1'b0;
      h_active      <= '0;
      v_active      <= '0;
      first_x       <= '0;
      have_first    <= 1'b0;
      line_mismatch <= 1'b0;
    end else begin
      pixel_valid <= vde_r;
      x           <= x_next;
      y           <= y_next;
      line_start  <= vde_rise;
      frame_start <= vde_rise & (y_next == '0);
      if (vs_edge) begin
        h_active      <= new_h;
        v_active      <= new_v;
        have_first    <= 1'b0;
        line_mismatch <= 1'b0;
      end else if (vde_fall) begin
        line_mismatch <= mis_eff;
        if (!have_first) begin
          first_x    <= x;
          have_first <= 1'b1;
        end
      end
    end
  end

  // clocks between hsync assert edges; counter restarts at 1 so the latched value is the full period
  always_ff @(posedge pixclk) begin
    if (reset) begin
      clk_cnt <= '0;
      h_total <= '0;
    end else if (hs_edge) begin
      h_total <= clk_cnt;
      clk_cnt <= {{(HW-1){1'b0}}, 1'b1};
    end else if (clk_cnt != HMAX) begin
      clk_cnt <= clk_cnt + 1'b1;
    end
  end

  // lock state register
  always_ff @(posedge pixclk) begin
    if (reset) begin
      state     <= SEARCH;
      match_cnt <= '0;
    end else begin
      state     <= state_next;
      match_cnt <= match_cnt_next;
    end
  end

  // lock next-state: frames are judged at vsync, over-long lines drop lock at once
  always_comb begin
    state_next     = state;
    match_cnt_next = match_cnt;
    match_inc      = match_cnt + 4'd1;
    case (state)
      SEARCH: begin
        match_cnt_next = '0;
        if (vs_edge) state_next = CHECK;
      end
      CHECK: begin
        if (vs_edge) begin
          if (frame_ok) begin
            match_cnt_next = match_inc;
            if (match_inc >= 4'(LOCK_FRAMES)) state_next = LOCKED;
          end else begin
            match_cnt_next = '0;
          end
        end
      end
      LOCKED: begin
        if (vs_edge && !frame_ok) begin
          state_next     = SEARCH;
          match_cnt_next = '0;
        end else if (vde_r && (x_next >= h_active)) begin
          state_next     = SEARCH;
          match_cnt_next = '0;
        end
      end
      default: begin
        state_next     = SEARCH;
        match_cnt_next = '0;
      end
    endcase
  end

  assign locked = (state == LOCKED);

endmodule
